// File: rtl/count_checker_pkg.sv
// count_checker_pkg: shared state encoding, display selects and defaults for the count checker
package count_checker_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;
  typedef enum logic [1:0] {
    SEL_ERR  = 2'd0,
    SEL_CAP  = 2'd1,
    SEL_GOOD = 2'd2,
    SEL_STAT = 2'd3
  } sel_t;
  localparam int ST_LOCKED  = 0;
  localparam int ST_ACQ     = 1;
  localparam int ST_ERR_NZ  = 2;
  localparam int ST_ERR_SAT = 3;
  localparam int ST_LOST    = 4;
  localparam int LOCK_COUNT_DEF = 4;
  localparam int LOSS_COUNT_DEF = 3;
endpackage

// File: rtl/seq_checker.sv
// seq_checker: captures the incoming count stream, tracks lock and accumulates statistics
module seq_checker
  import count_checker_pkg::*;
#(
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int LOSS_COUNT = LOSS_COUNT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sample,
  input  logic        sample_vld,
  input  logic        clr,
  output logic [7:0]  cap,
  output state_t      state,
  output logic [7:0]  err_cnt,
  output logic [15:0] good_cnt,
  output logic        lost
);
  localparam logic [2:0] LOCK_N = 3'(LOCK_COUNT);
  localparam logic [1:0] LOSS_N = 2'(LOSS_COUNT);
  logic       cap_vld;
  logic [7:0] exp;
  logic [2:0] run;
  logic [1:0] miss;
  logic       hit;
  logic [2:0] run_nx;
  logic [1:0] miss_nx;
  assign hit     = cap == exp;
  assign run_nx  = run + 3'd1;
  assign miss_nx = miss + 2'd1;
  // input capture: only the registered sample is ever compared
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cap     <= '0;
      cap_vld <= 1'b0;
    end else begin
      cap_vld <= sample_vld;
      if (sample_vld) cap <= sample;
    end
  // lock FSM; once locked exp free-runs so a lone glitch costs one error
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      exp   <= '0;
      run   <= '0;
      miss  <= '0;
    end else if (!cap_vld) begin
      state <= IDLE;
      run   <= '0;
      miss  <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= ACQUIRE;
          exp   <= cap + 8'd1;
          run   <= 3'd1;
        end
        ACQUIRE: begin
          exp <= cap + 8'd1;
          run <= hit ? run_nx : 3'd1;
          if (hit && run_nx == LOCK_N) begin
            state <= LOCKED;
            miss  <= '0;
          end
        end
        LOCKED: begin
          exp  <= exp + 8'd1;
          miss <= hit ? 2'd0 : miss_nx;
          if (!hit && miss_nx == LOSS_N) begin
            state <= ACQUIRE;
            run   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  // statistics, updated only while locked; clear has priority
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err_cnt  <= '0;
      good_cnt <= '0;
      lost     <= 1'b0;
    end else if (clr) begin
      err_cnt  <= '0;
      good_cnt <= '0;
      lost     <= 1'b0;
    end else if (cap_vld && state == LOCKED) begin
      if (hit) good_cnt <= good_cnt + 16'd1;
      else begin
        err_cnt <= err_cnt + {7'd0, err_cnt != 8'hFF};
        if (miss_nx == LOSS_N) lost <= 1'b1;
      end
    end
endmodule

// File: rtl/tt_um_count_checker.sv
// tt_um_count_checker: pin mapping and statistic display around seq_checker
module tt_um_count_checker
  import count_checker_pkg::*;
#(
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int LOSS_COUNT = LOSS_COUNT_DEF
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);
  logic [7:0]  cap;
  state_t      state;
  logic [7:0]  err_cnt;
  logic [15:0] good_cnt;
  logic        lost;
  logic [7:0]  status;
  logic [1:0]  sel;
  logic        unused;
  seq_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT)) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample     (uio_in),
    .sample_vld (ui_in[0]),
    .clr        (ui_in[1]),
    .cap        (cap),
    .state      (state),
    .err_cnt    (err_cnt),
    .good_cnt   (good_cnt),
    .lost       (lost)
  );
  assign sel = ui_in[3:2];
  // status byte assembled from registered flags
  always_comb begin
    status             = '0;
    status[ST_LOCKED]  = state == LOCKED;
    status[ST_ACQ]     = state == ACQUIRE;
    status[ST_ERR_NZ]  = err_cnt != 8'h00;
    status[ST_ERR_SAT] = err_cnt == 8'hFF;
    status[ST_LOST]    = lost;
  end
  assign uo_out  = sel == SEL_ERR  ? err_cnt :
                   sel == SEL_CAP  ? cap :
                   sel == SEL_GOOD ? good_cnt[7:0] : status;
  assign uio_out = '0;
  assign uio_oe  = '0;
  assign unused  = &{1'b0, ena, ui_in[7:4], good_cnt[15:8]};
endmodule

// File: tb/tb_tt_um_count_checker.sv
// tb_tt_um_count_checker: directed vector table plus hand sequences for the count checker
module tb_tt_um_count_checker;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic ena, clk, rst_n;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       en;
    logic       clr;
    logic [1:0] sel;
    logic [7:0] din;
    logic [7:0] want;
  } vec_t;
  vec_t tv[34];

  tt_um_count_checker dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h", name, act, req);
    end
  endtask

  task automatic step(input logic en, input logic clr, input logic [1:0] sel, input logic [7:0] d);
    ui_in  = {4'b0, sel, clr, en};
    uio_in = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic peek(input logic [1:0] sel, input logic [7:0] req, input string name);
    ui_in[3:2] = sel;
    #1;
    check(name, uo_out, req);
  endtask

  initial begin
    logic [7:0] e;
    ena = 1'b1;
    rst_n = 1'b0;
    ui_in = '0;
    uio_in = '0;
    // main stream: lock, wrap, glitch, loss/relock, clear-vs-mismatch
    tv[0]  = '{1'b1, 1'b0, 2'd3, 8'h10, 8'h00};
    tv[1]  = '{1'b1, 1'b0, 2'd3, 8'h11, 8'h02};
    tv[2]  = '{1'b1, 1'b0, 2'd3, 8'h12, 8'h02};
    tv[3]  = '{1'b1, 1'b0, 2'd3, 8'h13, 8'h02};
    tv[4]  = '{1'b1, 1'b0, 2'd3, 8'h14, 8'h01};
    tv[5]  = '{1'b1, 1'b0, 2'd0, 8'h15, 8'h00};
    tv[6]  = '{1'b1, 1'b0, 2'd2, 8'h16, 8'h02};
    tv[7]  = '{1'b1, 1'b0, 2'd1, 8'h17, 8'h17};
    tv[8]  = '{1'b0, 1'b0, 2'd3, 8'h00, 8'h01};
    tv[9]  = '{1'b1, 1'b1, 2'd3, 8'hFD, 8'h00};
    tv[10] = '{1'b1, 1'b0, 2'd2, 8'hFE, 8'h00};
    tv[11] = '{1'b1, 1'b0, 2'd3, 8'hFF, 8'h02};
    tv[12] = '{1'b1, 1'b0, 2'd3, 8'h00, 8'h02};
    tv[13] = '{1'b1, 1'b0, 2'd3, 8'h01, 8'h01};
    tv[14] = '{1'b1, 1'b0, 2'd3, 8'h02, 8'h01};
    tv[15] = '{1'b1, 1'b0, 2'd3, 8'h03, 8'h01};
    tv[16] = '{1'b1, 1'b0, 2'd3, 8'h04, 8'h01};
    tv[17] = '{1'b1, 1'b0, 2'd2, 8'h05, 8'h04};
    tv[18] = '{1'b1, 1'b0, 2'd0, 8'h99, 8'h00};
    tv[19] = '{1'b1, 1'b0, 2'd0, 8'h07, 8'h01};
    tv[20] = '{1'b1, 1'b0, 2'd3, 8'h08, 8'h05};
    tv[21] = '{1'b1, 1'b0, 2'd2, 8'h09, 8'h07};
    tv[22] = '{1'b1, 1'b1, 2'd0, 8'hAA, 8'h00};
    tv[23] = '{1'b1, 1'b0, 2'd0, 8'hAB, 8'h01};
    tv[24] = '{1'b1, 1'b0, 2'd0, 8'hAC, 8'h02};
    tv[25] = '{1'b1, 1'b0, 2'd3, 8'h40, 8'h16};
    tv[26] = '{1'b1, 1'b0, 2'd0, 8'h41, 8'h03};
    tv[27] = '{1'b1, 1'b0, 2'd3, 8'h42, 8'h16};
    tv[28] = '{1'b1, 1'b0, 2'd3, 8'h43, 8'h16};
    tv[29] = '{1'b1, 1'b0, 2'd3, 8'h44, 8'h15};
    tv[30] = '{1'b1, 1'b0, 2'd3, 8'h55, 8'h15};
    tv[31] = '{1'b1, 1'b1, 2'd3, 8'h46, 8'h01};
    tv[32] = '{1'b1, 1'b0, 2'd0, 8'h47, 8'h00};
    tv[33] = '{1'b1, 1'b0, 2'd2, 8'h48, 8'h02};

    repeat (2) @(negedge clk);
    peek(2'd0, 8'h00, "rst_err");
    peek(2'd1, 8'h00, "rst_cap");
    peek(2'd2, 8'h00, "rst_good");
    peek(2'd3, 8'h00, "rst_status");
    check("rst_uio_out", uio_out, 8'h00);
    check("rst_uio_oe", uio_oe, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 34; i++) begin
      step(tv[i].en, tv[i].clr, tv[i].sel, tv[i].din);
      if (uo_out !== tv[i].want) begin
        n_bad++;
        $display("FAIL vec%0d: got %02h want %02h", i, uo_out, tv[i].want);
      end
      n_cmp++;
    end

    // saturation: two misses then a hit keeps the loss threshold out of reach
    e = 8'h49;
    for (int i = 0; i < 150; i++) begin
      step(1'b1, 1'b0, 2'd0, e + 8'h80);
      e = e + 8'd1;
      step(1'b1, 1'b0, 2'd0, e + 8'h80);
      e = e + 8'd1;
      step(1'b1, 1'b0, 2'd0, e);
      e = e + 8'd1;
    end
    step(1'b1, 1'b0, 2'd0, e);
    peek(2'd0, 8'hFF, "sat_err");
    peek(2'd2, 8'h99, "sat_good");
    peek(2'd3, 8'h0D, "sat_status");

    // single-cycle enable drop forces re-acquisition, counters kept
    step(1'b0, 1'b0, 2'd0, 8'h00);
    check("endrop_err", uo_out, 8'hFF);
    step(1'b1, 1'b0, 2'd3, 8'h10);
    check("endrop_idle", uo_out, 8'h0C);
    step(1'b1, 1'b0, 2'd3, 8'h11);
    check("endrop_acq", uo_out, 8'h0E);
    peek(2'd2, 8'h9A, "endrop_good");

    // asynchronous reset mid-stream
    step(1'b1, 1'b0, 2'd0, 8'h12);
    rst_n = 1'b0;
    peek(2'd0, 8'h00, "arst_err");
    peek(2'd1, 8'h00, "arst_cap");
    peek(2'd2, 8'h00, "arst_good");
    peek(2'd3, 8'h00, "arst_status");
    check("arst_uio_out", uio_out, 8'h00);
    check("arst_uio_oe", uio_oe, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 2'd3, 8'h20);
    check("post_rst_idle", uo_out, 8'h00);
    step(1'b1, 1'b0, 2'd3, 8'h21);
    check("post_rst_acq", uo_out, 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
